// File: rtl/avalon_pkg.sv
// Shared types for the frame-buffer bus responder: response codes, FSM states
// and the write-response decode.
package avalon_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    SLVERR      = 2'b10,
    DECODEERROR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    INIT,
    READY,
    FULL
  } state_t;

  // A simultaneous read+write is rejected before the address is even looked at.
  function automatic resp_t wr_resp_code(input logic collide, input logic in_range);
    if (collide)       return SLVERR;
    else if (!in_range) return DECODEERROR;
    else               return OKAY;
  endfunction

endpackage

// File: rtl/read_resp_pipe.sv
// Fixed-latency read response delay line: {valid, data, resp} shifted one stage
// per clock, last stage drives the bus.
module read_resp_pipe #(
  parameter int LAT    = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_resp,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_resp
);

  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0][DATA_W-1:0] data_pipe;
  logic [LAT-1:0][1:0]        resp_pipe;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
      resp_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      data_pipe[0] <= in_data;
      resp_pipe[0] <= in_resp;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
        resp_pipe[i] <= resp_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[LAT-1];
  assign out_data  = data_pipe[LAT-1];
  assign out_resp  = resp_pipe[LAT-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Memory-mapped responder backing the frame-buffer bus with an internal word
// array; zero-fills on reset, fixed-latency reads, per-write responses.
module avalon_mem_responder
  import avalon_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic [1:0]          rresp,
  output logic                writeresponsevalid,
  output logic [1:0]          wresp
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic [PEND_W-1:0] pending;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range, accept, rd_acc, wr_acc, mem_we, retire;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  resp_t             rd_resp;

  assign waitrequest = (state != READY);
  assign in_range    = {1'b0, address} < DEPTH_CMP;
  assign idx         = address[IDX_W-1:0];
  assign accept      = (read | write) & ~waitrequest;
  // read+write together is handled purely as a (rejected) write
  assign rd_acc      = accept & read & ~write;
  assign wr_acc      = accept & write;
  assign mem_we      = wr_acc & ~read & in_range;

  assign rd_word = in_range ? mem[idx] : '0;
  assign rd_resp = in_range ? OKAY : DECODEERROR;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == IDX_W'(DEPTH - 1)) state_nxt = READY;
      READY:   if (rd_acc && !retire && pending == PEND_W'(MAX_PENDING - 1)) state_nxt = FULL;
      FULL:    if (retire) state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      init_cnt <= '0;
      pending  <= '0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + IDX_W'(1);
      case ({rd_acc, retire})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep zero-fills it after every reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < BE_W; b++)
        if (byteenable[b]) mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      writeresponsevalid <= 1'b0;
      wresp              <= OKAY;
    end else begin
      writeresponsevalid <= wr_acc;
      if (wr_acc) wresp <= wr_resp_code(read, in_range);
    end
  end

  read_resp_pipe #(
    .LAT    (READ_LATENCY),
    .DATA_W (DATA_W)
  ) u_read_resp_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .in_resp   (rd_resp),
    .out_valid (retire),
    .out_data  (readdata),
    .out_resp  (rresp)
  );

  assign readdatavalid = retire;

endmodule

// File: tb/tb_avalon_mem_responder.sv
`timescale 1ns/1ps
// Randomized + directed bench for avalon_mem_responder against a queue-based
// behavioural model checked on every falling edge.
module tb_avalon_mem_responder;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 4;
  localparam int MAXP   = 2;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [ADDR_W-1:0] address;
  logic              read, write;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic              waitrequest, readdatavalid, writeresponsevalid;
  logic [DATA_W-1:0] readdata;
  logic [1:0]        rresp, wresp;

  always #5 clk = ~clk;

  avalon_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .n_rst(n_rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .rresp(rresp),
    .writeresponsevalid(writeresponsevalid), .wresp(wresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t        rq[$];
  rsp_t        wq[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          init_left = DEPTH;
  bit          full_m = 0;

  always @(negedge clk) begin : model
    bit   ew, erv, ewv;
    rsp_t r;
    if (!n_rst) begin
      rq.delete();
      wq.delete();
      full_m    = 0;
      init_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
      chk("rst_waitrequest", waitrequest, 1);
      chk("rst_readdatavalid", readdatavalid, 0);
      chk("rst_writeresponsevalid", writeresponsevalid, 0);
      chk("rst_readdata", readdata, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_wresp", wresp, 0);
    end else begin
      ew = (init_left > 0) || full_m;
      chk("waitrequest", waitrequest, ew);
      erv = (rq.size() > 0) && (rq[0].due == cyc);
      chk("readdatavalid", readdatavalid, erv);
      if (erv) begin
        r = rq.pop_front();
        if (readdatavalid) begin
          chk("readdata", readdata, r.data);
          chk("rresp", rresp, r.resp);
        end
      end
      ewv = (wq.size() > 0) && (wq[0].due == cyc);
      chk("writeresponsevalid", writeresponsevalid, ewv);
      if (ewv) begin
        r = wq.pop_front();
        if (writeresponsevalid) chk("wresp", wresp, r.resp);
      end
      if (init_left > 0) init_left--;
      // command presented now is accepted at the coming rising edge
      if (!ew && (read || write)) begin
        r.data = '0;
        if (write) begin
          r.due = cyc + 1;
          if (read) r.resp = 2'b10;
          else if (address >= DEPTH) r.resp = 2'b11;
          else begin
            r.resp = 2'b00;
            for (int b = 0; b < 4; b++)
              if (byteenable[b]) mem_m[int'(address)][b*8 +: 8] = writedata[b*8 +: 8];
          end
          wq.push_back(r);
        end else begin
          r.due = cyc + LAT;
          if (address < DEPTH) begin
            r.data = mem_m[int'(address)];
            r.resp = 2'b00;
          end else r.resp = 2'b11;
          rq.push_back(r);
          if (!erv && rq.size() == MAXP) full_m = 1;
        end
      end
      if (erv) full_m = 0;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int g;
    g = 0;
    @(posedge clk); #2;
    read = r; write = w; address = a; writedata = d; byteenable = be;
    @(negedge clk);
    while (waitrequest && g < 200) begin
      g++;
      @(negedge clk);
    end
    chk("issue_accept", g < 200, 1);
    @(posedge clk); #2;
    read = 0; write = 0;
  endtask

  task automatic wait_rd(output logic [31:0] d, output logic [1:0] rs, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!readdatavalid && lat < 100);
    d = readdata;
    rs = rresp;
  endtask

  task automatic wait_wr(output logic [1:0] rs, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!writeresponsevalid && lat < 100);
    rs = wresp;
  endtask

  task automatic count_init(output int cnt, output int rv_seen);
    cnt = 0;
    rv_seen = 0;
    @(negedge clk);
    while (waitrequest && cnt < 200) begin
      cnt++;
      if (readdatavalid || writeresponsevalid) rv_seen++;
      @(negedge clk);
    end
  endtask

  bit wh [12];

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    int          lat, cnt, rv, st, first_rv, outst, max_o;
    bit          hold;
    read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;

    repeat (3) @(posedge clk);
    #2 n_rst = 1;
    count_init(cnt, rv);
    chk("init_len", cnt, DEPTH);

    // read of a freshly cleared word
    issue(1, 0, 5, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd5_data", d, 0);
    chk("rd5_resp", rs, 0);
    chk("rd5_lat", lat, LAT);

    // byte-enable merge
    issue(0, 1, 3, 32'hDEADBEEF, 4'b1111);
    wait_wr(rs, lat);
    chk("wr3a_lat", lat, 1);
    chk("wr3a_resp", rs, 0);
    issue(0, 1, 3, 32'h000000AA, 4'b0001);
    wait_wr(rs, lat);
    chk("wr3b_lat", lat, 1);
    issue(1, 0, 3, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd3_merge", d, 32'hDEADBEAA);

    // decode errors leave storage (including aliased index) untouched
    issue(0, 1, 15, 32'h12345678, 4'hF);
    wait_wr(rs, lat);
    issue(1, 0, 20, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd20_data", d, 0);
    chk("rd20_resp", rs, 2'b11);
    issue(0, 1, 31, 32'hCAFEF00D, 4'hF);
    wait_wr(rs, lat);
    chk("wr31_resp", rs, 2'b11);
    issue(1, 0, 15, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd15_intact", d, 32'h12345678);

    // read+write collision
    issue(0, 1, 2, 32'h5A5A5A5A, 4'hF);
    wait_wr(rs, lat);
    issue(1, 1, 2, 32'hFFFFFFFF, 4'hF);
    wait_wr(rs, lat);
    chk("collide_resp", rs, 2'b10);
    rv = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (readdatavalid) rv++;
    end
    chk("collide_no_rd", rv, 0);
    issue(1, 0, 2, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd2_intact", d, 32'h5A5A5A5A);

    // read held continuously: pending limit and stall length
    for (int i = 8; i < 12; i++) begin
      issue(0, 1, ADDR_W'(i), 32'h100 + i, 4'hF);
      wait_wr(rs, lat);
    end
    repeat (LAT + 2) @(negedge clk);
    @(posedge clk); #2;
    read = 1; write = 0; address = 8;
    first_rv = -1; outst = 0; max_o = 0;
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      wh[it] = waitrequest;
      if (readdatavalid) begin
        outst--;
        if (first_rv < 0) first_rv = it;
      end
      if (!waitrequest) outst++;
      if (outst > max_o) max_o = outst;
      @(posedge clk); #2;
      if (!wh[it]) address = address + 1'b1;
    end
    read = 0;
    st = 0;
    for (int it = 2; it < 12 && wh[it]; it++) st++;
    chk("held_acc0", wh[0], 0);
    chk("held_acc1", wh[1], 0);
    chk("held_stall", st, LAT - 1);
    chk("held_first_rv", first_rv, LAT);
    chk("held_max_pending", max_o, MAXP);
    repeat (LAT + 4) @(negedge clk);

    // randomized traffic, small address window incl. out-of-range
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (!hold) begin
        int op;
        op = $urandom_range(0, 9);
        read       = (op <= 3) || (op == 8);
        write      = (op >= 4 && op <= 8);
        address    = ADDR_W'($urandom_range(0, 19));
        writedata  = $urandom;
        byteenable = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      hold = (read || write) && waitrequest;
    end
    @(posedge clk); #2;
    read = 0; write = 0;
    repeat (LAT + 4) @(negedge clk);

    // reset with reads in flight
    @(posedge clk); #2;
    read = 1; address = 4;
    @(negedge clk);
    @(posedge clk); #2;
    address = 5;
    @(negedge clk);
    @(posedge clk); #2;
    n_rst = 0; read = 0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1;
    count_init(cnt, rv);
    chk("reinit_len", cnt, DEPTH);
    chk("reinit_no_resp", rv, 0);
    issue(1, 0, 3, 0, 0);
    wait_rd(d, rs, lat);
    chk("rd3_after_reset", d, 0);
    chk("rd3_after_reset_resp", rs, 0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
